// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sequencer: opcodes, FSM encoding, word width.
package ula_pkg;

    localparam int TAMANHO_PADRAO = 16;

    localparam logic [3:0] OP_SOMA         = 4'd0;
    localparam logic [3:0] OP_SUBTRACAO    = 4'd1;
    localparam logic [3:0] OP_MULTIPLICACAO = 4'd2;
    localparam logic [3:0] OP_DIVISAO      = 4'd3;
    localparam logic [3:0] OP_E            = 4'd4;
    localparam logic [3:0] OP_NE           = 4'd5;
    localparam logic [3:0] OP_OU           = 4'd6;
    localparam logic [3:0] OP_XOU          = 4'd7;
    localparam logic [3:0] OP_CMP          = 4'd8;
    localparam logic [3:0] OP_NAO          = 4'd9;
    localparam logic [3:0] OP_MAX          = 4'd9;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        REQUISITA = 2'd1,
        ESCREVE   = 2'd2,
        ERRO      = 2'd3
    } estado_t;

    // True when the opcode lies in the valid range 0..OP_MAX.
    function automatic logic op_valido(input logic [3:0] codigo);
        return (codigo <= OP_MAX);
    endfunction

endpackage

// File: rtl/ula_sequenciador_if.sv
// Instruction handshake bus between an instruction source and the sequencer.
interface ula_sequenciador_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rd;
    logic [2:0] instr_rs;

    modport master (
        output instr_valid,
        output instr_op,
        output instr_rd,
        output instr_rs,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_op,
        input  instr_rd,
        input  instr_rs,
        output instr_ready
    );
endinterface

// File: rtl/ula_banco_regs.sv
// Register bank: one write port, three combinational read ports, async clear.
module ula_banco_regs #(
    parameter int W  = 16,
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [W-1:0]  rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_b,
    input  logic [AW-1:0] raddr_c,
    output logic [W-1:0]  rdata_c
);

    logic [W-1:0] mem_r [N];

    // Storage array: cleared on reset, single write per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_r[raddr_a];
    assign rdata_b = mem_r[raddr_b];
    assign rdata_c = mem_r[raddr_c];

endmodule

// File: rtl/ula_sequenciador.sv
// Instruction sequencer feeding the ULA: reads operands from the bank, hands
// them to the ULA, waits for completion (with watchdog) and writes back.
// Optional build macro: ULA_SEQ_FLAGS_EN adds flag_z / flag_n outputs.
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int Tamanho_Da_Palavra = TAMANHO_PADRAO,
    parameter int NUM_REGS           = 8,
    parameter int TIMEOUT_CICLOS     = 64,
    parameter int AW                 = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset,
    ula_sequenciador_if.slave             instr,
    input  logic                          ext_we,
    input  logic [AW-1:0]                 ext_addr,
    input  logic [Tamanho_Da_Palavra-1:0] ext_wdata,
    output logic [Tamanho_Da_Palavra-1:0] ext_rdata,
    output logic [Tamanho_Da_Palavra-1:0] ETp1,
    output logic [Tamanho_Da_Palavra-1:0] ETp2,
    output logic [3:0]                    op,
    output logic                          processar,
    input  logic                          concluido,
    input  logic [Tamanho_Da_Palavra-1:0] Data,
    output logic                          feito,
    output logic                          erro,
    output logic [Tamanho_Da_Palavra-1:0] resultado
`ifdef ULA_SEQ_FLAGS_EN
    ,
    output logic                          flag_z,
    output logic                          flag_n
`endif
);

    localparam int W    = Tamanho_Da_Palavra;
    localparam int WD_W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [WD_W-1:0] WD_LIMITE = WD_W'(TIMEOUT_CICLOS - 1);

    estado_t         estado_r;
    estado_t         estado_s;
    logic [AW-1:0]   rd_r;
    logic [W-1:0]    res_r;
    logic [WD_W-1:0] wd_r;
    logic            aceita_s;

    logic            we_s;
    logic [AW-1:0]   waddr_s;
    logic [W-1:0]    wdata_s;
    logic [W-1:0]    rd_dado_s;
    logic [W-1:0]    rs_dado_s;

    assign instr.instr_ready = (estado_r == OCIOSO);
    assign aceita_s = (estado_r == OCIOSO) && instr.instr_valid && op_valido(instr.instr_op);

    ula_banco_regs #(
        .W  (W),
        .N  (NUM_REGS),
        .AW (AW)
    ) u_banco (
        .clk     (clk),
        .reset   (reset),
        .we      (we_s),
        .waddr   (waddr_s),
        .wdata   (wdata_s),
        .raddr_a (instr.instr_rd),
        .rdata_a (rd_dado_s),
        .raddr_b (instr.instr_rs),
        .rdata_b (rs_dado_s),
        .raddr_c (ext_addr),
        .rdata_c (ext_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= estado_s;
        end
    end

    // FSM next-state: accept, wait for the ULA or the watchdog, retire.
    always_comb begin
        estado_s = estado_r;
        case (estado_r)
            OCIOSO: begin
                if (instr.instr_valid) begin
                    if (op_valido(instr.instr_op)) begin
                        estado_s = REQUISITA;
                    end else begin
                        estado_s = ERRO;
                    end
                end else begin
                    estado_s = OCIOSO;
                end
            end
            REQUISITA: begin
                if (concluido) begin
                    estado_s = ESCREVE;
                end else if (wd_r == WD_LIMITE) begin
                    estado_s = ERRO;
                end else begin
                    estado_s = REQUISITA;
                end
            end
            ESCREVE: estado_s = OCIOSO;
            ERRO:    estado_s = OCIOSO;
            default: estado_s = OCIOSO;
        endcase
    end

    // Bank write port: external init only while idle, writeback in ESCREVE.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = ext_addr;
        wdata_s = ext_wdata;
        if (estado_r == OCIOSO) begin
            we_s = ext_we;
        end else if (estado_r == ESCREVE) begin
            we_s    = (op != OP_CMP);
            waddr_s = rd_r;
            wdata_s = res_r;
        end else begin
            we_s = 1'b0;
        end
    end

    // Datapath and registered ULA-side / status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ETp1      <= {W{1'b0}};
            ETp2      <= {W{1'b0}};
            op        <= 4'd0;
            rd_r      <= {AW{1'b0}};
            res_r     <= {W{1'b0}};
            wd_r      <= {WD_W{1'b0}};
            processar <= 1'b0;
            feito     <= 1'b0;
            erro      <= 1'b0;
            resultado <= {W{1'b0}};
`ifdef ULA_SEQ_FLAGS_EN
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
`endif
        end else begin
            processar <= (estado_s == REQUISITA);
            feito     <= (estado_r == ESCREVE);
            erro      <= (estado_r == ERRO);

            if (aceita_s) begin
                ETp1 <= rd_dado_s;
                ETp2 <= (instr.instr_op == OP_NAO) ? {W{1'b0}} : rs_dado_s;
                op   <= instr.instr_op;
                rd_r <= instr.instr_rd;
            end

            // Watchdog runs only while waiting for the ULA.
            if ((estado_r == REQUISITA) && !concluido) begin
                wd_r <= wd_r + WD_W'(1);
            end else begin
                wd_r <= {WD_W{1'b0}};
            end

            if ((estado_r == REQUISITA) && concluido) begin
                res_r <= Data;
            end

            if (estado_r == ESCREVE) begin
                resultado <= res_r;
`ifdef ULA_SEQ_FLAGS_EN
                flag_z    <= (res_r == {W{1'b0}});
                flag_n    <= res_r[W-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ula_sequenciador.sv
// Self-checking bench for ula_sequenciador: table of single-instruction
// vectors plus hand-written sequences (timeout, reset, ext-write corners).
module tb_ula_sequenciador;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ext_we = 1'b0;
    logic [2:0]  ext_addr = 3'd0;
    logic [15:0] ext_wdata = 16'h0000;
    logic [15:0] ext_rdata;
    logic [15:0] ETp1, ETp2, resultado;
    logic [3:0]  op;
    logic        processar, feito, erro;
    logic        concluido = 1'b0;
    logic [15:0] Data = 16'h0000;
`ifdef ULA_SEQ_FLAGS_EN
    logic        flag_z, flag_n;
`endif

    ula_sequenciador_if ibus();

    ula_sequenciador dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (ibus),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ETp1      (ETp1),
        .ETp2      (ETp2),
        .op        (op),
        .processar (processar),
        .concluido (concluido),
        .Data      (Data),
        .feito     (feito),
        .erro      (erro),
        .resultado (resultado)
`ifdef ULA_SEQ_FLAGS_EN
        ,
        .flag_z    (flag_z),
        .flag_n    (flag_n)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int model_lat = 0;
    int mcnt = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] ula_ref(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return 16'(a * b);
            4'd3: return (b == 16'h0000) ? 16'hFFFF : a / b;
            4'd4: return a & b;
            4'd5: return ~(a & b);
            4'd6: return a | b;
            4'd7: return a ^ b;
            4'd8: return a - b;
            4'd9: return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    // ULA model: raises concluido after model_lat cycles of processar (0 = never).
    always @(negedge clk) begin
        if (processar) begin
            mcnt = mcnt + 1;
            concluido = (model_lat != 0) && (mcnt == model_lat);
        end else begin
            mcnt = 0;
            concluido = 1'b0;
        end
        Data = ula_ref(op, ETp1, ETp2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
        ext_we = 1'b1; ext_addr = a; ext_wdata = d;
        @(posedge clk); #1;
        ext_we = 1'b0;
    endtask

    task automatic read_bank(input logic [2:0] a, output logic [15:0] d);
        ext_addr = a;
        #1;
        d = ext_rdata;
    endtask

    task automatic start_instr(input logic [3:0] o, input logic [2:0] rd, input logic [2:0] rs);
        ibus.instr_valid = 1'b1; ibus.instr_op = o; ibus.instr_rd = rd; ibus.instr_rs = rs;
        @(posedge clk); #1;
        ibus.instr_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [15:0] e1, input logic [15:0] e2, input logic [3:0] eo,
                             output int pcnt, output int cyc, output bit f, output bit e);
        bit done;
        pcnt = 0; cyc = 0; f = 1'b0; e = 1'b0; done = 1'b0;
        for (int c = 1; c <= 200 && !done; c++) begin
            if (processar) begin
                pcnt++;
                check("etp1_stable", {16'h0, ETp1}, {16'h0, e1});
                check("etp2_stable", {16'h0, ETp2}, {16'h0, e2});
                check("op_stable", {28'h0, op}, {28'h0, eo});
            end
            if (feito || erro) begin
                cyc = c; f = feito; e = erro; done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_check(input string name);
        logic [15:0] ex;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            check(name, {16'h0, resultado}, {16'h0, ex});
        end else begin
            check("scoreboard_empty_on_feito", 32'd0, 32'd1);
        end
    endtask

    typedef struct {
        logic [3:0]  o;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int pcnt, cyc;
        bit f, e, is_err, is_cmp;
        logic [15:0] rv, e2, r, b_eff;

        ibus.instr_valid = 1'b0; ibus.instr_op = 4'd0; ibus.instr_rd = 3'd0; ibus.instr_rs = 3'd0;

        vecs[0]  = '{4'd0,  3'd1, 3'd2, 16'h0005, 16'h0003, 3};
        vecs[1]  = '{4'd1,  3'd4, 3'd5, 16'h0010, 16'h0003, 1};
        vecs[2]  = '{4'd2,  3'd6, 3'd7, 16'h0100, 16'h0100, 2};
        vecs[3]  = '{4'd3,  3'd0, 3'd7, 16'h0064, 16'h0007, 5};
        vecs[4]  = '{4'd4,  3'd0, 3'd1, 16'hF0F0, 16'h0FF0, 1};
        vecs[5]  = '{4'd5,  3'd2, 3'd3, 16'hFFFF, 16'h0F0F, 2};
        vecs[6]  = '{4'd6,  3'd4, 3'd6, 16'h1200, 16'h0034, 3};
        vecs[7]  = '{4'd7,  3'd5, 3'd5, 16'hABCD, 16'hABCD, 1};
        vecs[8]  = '{4'd9,  3'd2, 3'd3, 16'h00FF, 16'h1111, 2};
        vecs[9]  = '{4'd8,  3'd3, 3'd3, 16'h1234, 16'h1234, 2};
        vecs[10] = '{4'd12, 3'd1, 3'd2, 16'h0A0A, 16'h0B0B, 0};
        vecs[11] = '{4'd15, 3'd7, 3'd0, 16'h7777, 16'h0000, 0};

        // Reset state
        #12;
        check("rst_processar", {31'h0, processar}, 32'd0);
        check("rst_feito", {31'h0, feito}, 32'd0);
        check("rst_erro", {31'h0, erro}, 32'd0);
        check("rst_resultado", {16'h0, resultado}, 32'd0);
        check("rst_etp1", {16'h0, ETp1}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", {31'h0, ibus.instr_ready}, 32'd1);

        // Table-driven single instructions
        for (int i = 0; i < 12; i++) begin
            ext_write(vecs[i].rs, vecs[i].b);
            ext_write(vecs[i].rd, vecs[i].a);
            model_lat = vecs[i].lat;
            is_err = (vecs[i].o > 4'd9);
            is_cmp = (vecs[i].o == 4'd8);
            b_eff  = (vecs[i].rd == vecs[i].rs) ? vecs[i].a : vecs[i].b;
            e2     = (vecs[i].o == 4'd9) ? 16'h0000 : b_eff;
            r      = ula_ref(vecs[i].o, vecs[i].a, e2);
            if (!is_err) exp_q.push_back(r);
            start_instr(vecs[i].o, vecs[i].rd, vecs[i].rs);
            wait_done(vecs[i].a, e2, vecs[i].o, pcnt, cyc, f, e);
            if (is_err) begin
                check($sformatf("v%0d_erro", i), {31'h0, e}, 32'd1);
                check($sformatf("v%0d_no_processar", i), pcnt, 32'd0);
                check($sformatf("v%0d_erro_cycle", i), cyc, 32'd2);
            end else begin
                check($sformatf("v%0d_feito", i), {31'h0, f}, 32'd1);
                check($sformatf("v%0d_proc_cycles", i), pcnt, vecs[i].lat);
                check($sformatf("v%0d_feito_cycle", i), cyc, vecs[i].lat + 2);
                pop_check($sformatf("v%0d_resultado", i));
`ifdef ULA_SEQ_FLAGS_EN
                check($sformatf("v%0d_flag_z", i), {31'h0, flag_z}, {31'h0, (r == 16'h0000)});
                check($sformatf("v%0d_flag_n", i), {31'h0, flag_n}, {31'h0, r[15]});
`endif
            end
            check($sformatf("v%0d_ready", i), {31'h0, ibus.instr_ready}, 32'd1);
            read_bank(vecs[i].rd, rv);
            check($sformatf("v%0d_bank_rd", i), {16'h0, rv}, {16'h0, (is_err || is_cmp) ? vecs[i].a : r});
            @(posedge clk); #1;
        end

        // Watchdog: ULA never completes
        ext_write(3'd5, 16'h0055);
        ext_write(3'd6, 16'h0006);
        model_lat = 0;
        start_instr(4'd0, 3'd5, 3'd6);
        wait_done(16'h0055, 16'h0006, 4'd0, pcnt, cyc, f, e);
        check("to_erro", {31'h0, e}, 32'd1);
        check("to_feito", {31'h0, f}, 32'd0);
        check("to_proc_cycles", pcnt, 32'd64);
        check("to_erro_cycle", cyc, 32'd66);
        read_bank(3'd5, rv);
        check("to_no_write", {16'h0, rv}, 32'h0055);
        @(posedge clk); #1;

        // ext_we during REQUISITA is ignored
        ext_write(3'd4, 16'h4444);
        ext_write(3'd1, 16'h0005);
        ext_write(3'd2, 16'h0003);
        model_lat = 4;
        exp_q.push_back(16'h0008);
        start_instr(4'd0, 3'd1, 3'd2);
        ext_we = 1'b1; ext_addr = 3'd4; ext_wdata = 16'hBEEF;
        @(posedge clk); #1;
        ext_we = 1'b0;
        wait_done(16'h0005, 16'h0003, 4'd0, pcnt, cyc, f, e);
        check("busy_we_feito", {31'h0, f}, 32'd1);
        pop_check("busy_we_resultado");
        read_bank(3'd4, rv);
        check("busy_we_ignored", {16'h0, rv}, 32'h4444);
        @(posedge clk); #1;

        // Same-cycle ext write and accept: operand sees old value
        ext_write(3'd1, 16'h0011);
        ext_write(3'd2, 16'h0003);
        model_lat = 3;
        exp_q.push_back(16'h0014);
        ext_we = 1'b1; ext_addr = 3'd1; ext_wdata = 16'h2222;
        start_instr(4'd0, 3'd1, 3'd2);
        ext_we = 1'b0;
        check("same_cycle_etp1_old", {16'h0, ETp1}, 32'h0011);
        read_bank(3'd1, rv);
        check("same_cycle_bank_new", {16'h0, rv}, 32'h2222);
        wait_done(16'h0011, 16'h0003, 4'd0, pcnt, cyc, f, e);
        check("same_cycle_feito", {31'h0, f}, 32'd1);
        pop_check("same_cycle_resultado");
        read_bank(3'd1, rv);
        check("same_cycle_writeback", {16'h0, rv}, 32'h0014);
        @(posedge clk); #1;

        // Reset in the middle of REQUISITA
        model_lat = 0;
        start_instr(4'd0, 3'd1, 3'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_rst_proc_before", {31'h0, processar}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_proc_dropped", {31'h0, processar}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            read_bank(i[2:0], rv);
            check($sformatf("mid_rst_bank%0d", i), {16'h0, rv}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", {31'h0, ibus.instr_ready}, 32'd1);
        check("mid_rst_proc_after", {31'h0, processar}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
